// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between a fetch port and a data port, with a starvation guard for fetches.
module bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_request,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_data,
  output logic                    i_done,
  input  logic                    d_request,
  input  logic                    d_write,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_select,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_done,
  output logic                    m_enable,
  output logic                    m_write,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_select,
  input  logic                    m_ready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    stall
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  state_t state, state_nx;
  logic [SW-1:0] starve;
  logic i_req, d_req, go_d, go_i, fin;
  // A requester still holding its request during its own done cycle is not asking again
  assign i_req = i_request & ~i_done;
  assign d_req = d_request & ~d_done;
  assign stall = i_req | d_req | (state != IDLE);
  always_comb begin
    go_d = (state == IDLE) && d_req && !(i_req && starve == SW'(MAX_WAIT));
    go_i = (state == IDLE) && i_req && !go_d;
    fin = (state != IDLE) && m_ready;
    state_nx = go_d ? D_BUSY : go_i ? I_BUSY : fin ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve <= '0;
      m_enable <= 1'b0;
      m_write <= 1'b0;
      m_address <= '0;
      m_wdata <= '0;
      m_select <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_data <= '0;
      d_data <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (go_d) begin
        m_enable <= 1'b1;
        m_write <= d_write;
        m_address <= d_address;
        m_wdata <= d_wdata;
        m_select <= d_select;
        if (i_req && starve != SW'(MAX_WAIT)) starve <= starve + SW'(1);
      end else if (go_i) begin
        m_enable <= 1'b1;
        m_write <= 1'b0;
        m_address <= i_address;
        m_wdata <= '0;
        m_select <= '1;
        starve <= '0;
      end else if (fin) begin
        m_enable <= 1'b0;
        if (state == I_BUSY) begin
          i_done <= 1'b1;
          i_data <= m_rdata;
        end else begin
          d_done <= 1'b1;
          if (!m_write) d_data <= m_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
  localparam int AW = 32, DW = 32, MW = 4;
  logic clock = 1'b0, reset;
  logic i_request, i_done, d_request, d_write, d_done, m_enable, m_write, m_ready, stall;
  logic [AW-1:0] i_address, d_address, m_address;
  logic [DW-1:0] i_data, d_wdata, d_data, m_wdata, m_rdata;
  logic [3:0] d_select, m_select;
  int checks = 0, errors = 0;
  int own, starve;
  logic e_en, e_wr, e_idone, e_ddone;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_idata, e_ddata;
  logic [3:0] e_sel;

  always #5 clock = ~clock;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .i_request(i_request), .i_address(i_address), .i_data(i_data), .i_done(i_done),
    .d_request(d_request), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_select(d_select), .d_data(d_data), .d_done(d_done),
    .m_enable(m_enable), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
    .m_select(m_select), .m_ready(m_ready), .m_rdata(m_rdata), .stall(stall)
  );

  task automatic model_reset();
    own = 0; starve = 0;
    e_en = 0; e_wr = 0; e_idone = 0; e_ddone = 0;
    e_addr = '0; e_wdata = '0; e_idata = '0; e_ddata = '0; e_sel = '0;
  endtask

  // own: 0 = bus free, 1 = fetch owns bus, 2 = data owns bus
  task automatic model_step();
    logic ir, dr;
    ir = i_request && !e_idone;
    dr = d_request && !e_ddone;
    e_idone = 0; e_ddone = 0;
    if (own == 0) begin
      if (dr && !(ir && starve == MW)) begin
        own = 2;
        if (ir && starve < MW) starve++;
        e_en = 1; e_wr = d_write; e_addr = d_address; e_wdata = d_wdata; e_sel = d_select;
      end else if (ir) begin
        own = 1; starve = 0;
        e_en = 1; e_wr = 0; e_addr = i_address; e_wdata = '0; e_sel = '1;
      end
    end else if (m_ready) begin
      if (own == 1) begin
        e_idone = 1; e_idata = m_rdata;
      end else begin
        e_ddone = 1;
        if (!e_wr) e_ddata = m_rdata;
      end
      own = 0; e_en = 0;
    end
  endtask

  function automatic logic exp_stall();
    return (i_request && !e_idone) || (d_request && !e_ddone) || own != 0;
  endfunction

  task automatic tick();
    if (!reset) model_step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    i_request = 0; i_address = '0; d_request = 0; d_write = 0; d_address = '0;
    d_wdata = '0; d_select = '0; m_ready = 0; m_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({m_enable, m_write, m_address, m_wdata, m_select, i_done, d_done, i_data, d_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b wr=%b a=%h wd=%h sel=%h id=%b dd=%b idata=%h ddata=%h",
               m_enable, m_write, m_address, m_wdata, m_select, i_done, d_done, i_data, d_data);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    reset = 0;
  endtask

  task automatic test_fetch();
    apply_reset();
    i_request = 1; i_address = 32'h4; m_ready = 1; m_rdata = 32'h34020404;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_req got %b want 1", stall); end
    tick();
    checks++;
    if ({m_enable, m_write, m_address, m_select, i_done} !== {1'b1, 1'b0, 32'h4, 4'hf, 1'b0}) begin
      errors++;
      $display("FAIL fetch_bus got en=%b wr=%b a=%h sel=%h id=%b want en=1 wr=0 a=4 sel=f id=0",
               m_enable, m_write, m_address, m_select, i_done);
    end
    i_request = 0;
    tick();
    checks++;
    if ({m_enable, i_done, i_data} !== {1'b0, 1'b1, 32'h34020404}) begin
      errors++;
      $display("FAIL fetch_done got en=%b id=%b data=%h want en=0 id=1 data=34020404", m_enable, i_done, i_data);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_done got %b want 0", stall); end
    tick();
    checks++;
    if ({m_enable, i_done, i_data} !== {1'b0, 1'b0, 32'h34020404}) begin
      errors++;
      $display("FAIL fetch_after got en=%b id=%b data=%h want en=0 id=0 data=34020404", m_enable, i_done, i_data);
    end
  endtask

  task automatic test_store_drop();
    apply_reset();
    d_request = 1; d_write = 1; d_address = 32'h100; d_wdata = 32'h80800000; d_select = 4'hf;
    m_ready = 0; m_rdata = 32'hdeadbeef;
    tick();
    d_request = 0; d_address = 32'h5555; d_wdata = 32'h1; d_select = 4'h1; d_write = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({m_enable, m_write, m_address, m_wdata, m_select, d_done} !== {1'b1, 1'b1, 32'h100, 32'h80800000, 4'hf, 1'b0}) begin
        errors++;
        $display("FAIL store_hold%0d got en=%b wr=%b a=%h wd=%h sel=%h dd=%b", k, m_enable, m_write, m_address, m_wdata, m_select, d_done);
      end
      m_ready = (k == 2);
      tick();
    end
    m_ready = 1;
    checks++;
    if ({m_enable, d_done, d_data} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL store_done got en=%b dd=%b ddata=%h want en=0 dd=1 ddata=0", m_enable, d_done, d_data);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({m_enable, d_done, stall} !== 3'b000) begin
        errors++;
        $display("FAIL drop_no_regrant%0d got en=%b dd=%b stall=%b want 000", k, m_enable, d_done, stall);
      end
    end
  endtask

  task automatic test_starve();
    int want[5] = '{2, 2, 2, 2, 1};
    int seen;
    apply_reset();
    i_address = 32'h40; d_address = 32'h80; m_ready = 1;
    for (int g = 0; g < 5; g++) begin
      i_request = 1; d_request = 1;
      tick();
      seen = !m_enable ? 0 : (m_address == 32'h40) ? 1 : 2;
      checks++;
      if (seen != want[g]) begin errors++; $display("FAIL starve_grant%0d got %0d want %0d", g, seen, want[g]); end
      i_request = 0; d_request = 0;
      repeat (2) tick();
    end
  endtask

  task automatic test_contention();
    int q[$];
    apply_reset();
    i_address = 32'h40; d_address = 32'h80; m_ready = 1;
    i_request = 1; d_request = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL contention_stall%0d got %b want 1", k, stall); end
      tick();
      if (m_enable) q.push_back(m_address == 32'h40 ? 1 : 2);
    end
    checks++;
    if (q.size() != 2 || q[0] != 2 || q[1] != 1) begin
      errors++;
      $display("FAIL contention_order got n=%0d first=%0d second=%0d want n=2 2,1", q.size(),
               q.size() > 0 ? q[0] : 0, q.size() > 1 ? q[1] : 0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    d_request = 1; d_write = 0; d_address = 32'h200; m_ready = 0; m_rdata = 32'h1234abcd;
    repeat (2) tick();
    checks++;
    if (m_enable !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", m_enable); end
    reset = 1;
    model_reset();
    #1;
    checks++;
    if ({m_enable, d_done, m_address} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_abort got en=%b dd=%b a=%h want 0 0 0", m_enable, d_done, m_address);
    end
    m_ready = 1;
    tick();
    checks++;
    if ({m_enable, d_done} !== 2'b00) begin errors++; $display("FAIL rstmid_held got en=%b dd=%b want 00", m_enable, d_done); end
    reset = 0;
    m_ready = 0;
    tick();
    checks++;
    if ({m_enable, m_address} !== {1'b1, 32'h200}) begin
      errors++;
      $display("FAIL rstmid_regrant got en=%b a=%h want 1 200", m_enable, m_address);
    end
    m_ready = 1; d_request = 0;
    tick();
    checks++;
    if ({d_done, d_data} !== {1'b1, 32'h1234abcd}) begin
      errors++;
      $display("FAIL rstmid_done got dd=%b data=%h want 1 1234abcd", d_done, d_data);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      i_request = ($urandom_range(0, 2) != 0);
      d_request = ($urandom_range(0, 2) != 0);
      d_write = $urandom_range(0, 1);
      i_address = $urandom; d_address = $urandom; d_wdata = $urandom;
      d_select = 4'($urandom); m_ready = ($urandom_range(0, 2) == 0); m_rdata = $urandom;
      #1;
      checks++;
      if (stall !== exp_stall()) begin errors++; $display("FAIL rand_stall c=%0d got %b want %b", c, stall, exp_stall()); end
      tick();
      checks++;
      if ({m_enable, i_done, d_done, i_data, d_data} !== {e_en, e_idone, e_ddone, e_idata, e_ddata}) begin
        errors++;
        $display("FAIL rand_out c=%0d got en=%b id=%b dd=%b idata=%h ddata=%h want en=%b id=%b dd=%b idata=%h ddata=%h",
                 c, m_enable, i_done, d_done, i_data, d_data, e_en, e_idone, e_ddone, e_idata, e_ddata);
      end
      if (e_en) begin
        checks++;
        if ({m_write, m_address, m_select} !== {e_wr, e_addr, e_sel} || (own == 2 && m_wdata !== e_wdata)) begin
          errors++;
          $display("FAIL rand_bus c=%0d got wr=%b a=%h sel=%h wd=%h want wr=%b a=%h sel=%h wd=%h",
                   c, m_write, m_address, m_select, m_wdata, e_wr, e_addr, e_sel, e_wdata);
        end
      end
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    model_reset();
    @(negedge clock);
    test_reset();
    test_fetch();
    test_store_drop();
    test_starve();
    test_contention();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
